alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/alu_result_stage.sv | 90 +++++++++
 tb/tb_alu_result_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: op-codes, result-stage state encoding and helpers shared by the ALU,
// the control unit and the result stage.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LO_BEAT = 2'd1,
        ST_HI_BEAT = 2'd2
    } res_state_t;

    // Multiply and divide produce a double-width result that lands in HI/LO.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

endpackage

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures an ALU result, updates HI/LO for mul/div and streams it out as lo/hi beats.
// Defining ALU_RESULT_FLAGS_EN adds a registered {carry, negative, zero} flags output.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          op_select,
    input  logic [2*DATA_W-1:0] z_in,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_is_hi,
`ifdef ALU_RESULT_FLAGS_EN
    output logic [2:0]          flags,
`endif
    output logic [DATA_W-1:0]   hi_q,
    output logic [DATA_W-1:0]   lo_q
);

    res_state_t          state, state_nx;
    logic [2*DATA_W-1:0] z_q;
    logic [3:0]          op_q;
    logic                carry_q;
    logic                accept;

    assign accept = state == ST_IDLE && in_valid;

    // Outputs decode straight from the state and captured result, so clear takes effect immediately.
    always_comb begin
        state_nx  = state;
        in_ready  = state == ST_IDLE;
        out_valid = state != ST_IDLE;
        out_is_hi = state == ST_HI_BEAT;
        out_data  = out_is_hi ? z_q[2*DATA_W-1:DATA_W] : out_valid ? z_q[DATA_W-1:0] : '0;
        if (accept)
            state_nx = ST_LO_BEAT;
        else if (state == ST_LO_BEAT && out_ready)
            state_nx = is_hilo_op(op_q) ? ST_HI_BEAT : ST_IDLE;
        else if (state == ST_HI_BEAT && out_ready)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= ST_IDLE;
            z_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                z_q     <= z_in;
                op_q    <= op_select;
                carry_q <= carry_in;
                if (is_hilo_op(op_select)) begin
                    hi_q <= z_in[2*DATA_W-1:DATA_W];
                    lo_q <= z_in[DATA_W-1:0];
                end
            end
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic neg_q, zero_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            neg_q  <= z_in[DATA_W-1];
            zero_q <= z_in[DATA_W-1:0] == '0;
        end
    end

    assign flags = {carry_q, neg_q, zero_q};
`else
    logic carry_unused;
    assign carry_unused = carry_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random stimulus; a reference model queues expected beats on
// every capture and an independent monitor checks each beat, stall stability and protocol.
module tb_alu_result_stage;
    import cpu_pkg::*;

    localparam int W = 32;

    logic           clock = 0, clear = 0, in_valid = 0, carry_in = 0, out_ready = 0;
    logic [3:0]     op_select = 0;
    logic [2*W-1:0] z_in = 0;
    logic           in_ready, out_valid, out_is_hi;
    logic [W-1:0]   out_data, hi_q, lo_q;
`ifdef ALU_RESULT_FLAGS_EN
    logic [2:0]     flags;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         is_hi;
        logic [2:0]   fl;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        b;
    logic [2:0]   fl;
    logic [W-1:0] exp_hi = 0, exp_lo = 0;
    int           checks = 0, failures = 0, clear_cnt = 0;
    logic [3:0]   ops[8] = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_DIV, OP_OR, OP_XOR, OP_SLT};

    always #5 clock = ~clock;

    alu_result_stage #(.DATA_W(W)) dut (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_select(op_select), .z_in(z_in), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_is_hi(out_is_hi),
`ifdef ALU_RESULT_FLAGS_EN
        .flags(flags),
`endif
        .hi_q(hi_q), .lo_q(lo_q)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted result yields its low half, plus the high half for mul/div.
    always @(negedge clock) begin
        if (in_valid && in_ready && !clear) begin
            fl = {carry_in, z_in[W-1], z_in[W-1:0] == 0};
            exp_q.push_back(beat_t'{z_in[W-1:0], 1'b0, fl});
            if (op_select == OP_MUL || op_select == OP_DIV) begin
                exp_q.push_back(beat_t'{z_in[2*W-1:W], 1'b1, fl});
                exp_hi = z_in[2*W-1:W];
                exp_lo = z_in[W-1:0];
            end
        end
    end

    logic [W-1:0] prev_data = 0;
    logic         prev_hi = 0, prev_stall = 0, prev_cap = 0;
    int           prev_clr = 0;

    always @(negedge clock) begin
        chk("ready_is_idle", in_ready, !out_valid);
        if (prev_clr == clear_cnt) begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_is_hi", out_is_hi, prev_hi);
            end
            if (prev_cap) begin
                chk("latency_valid", out_valid, 1);
                chk("latency_is_lo", out_is_hi, 0);
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat got=%h expected=none t=%0t", out_data, $time);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", out_data, b.data);
                chk("beat_is_hi", out_is_hi, b.is_hi);
                chk("beat_hi_q", hi_q, exp_hi);
                chk("beat_lo_q", lo_q, exp_lo);
`ifdef ALU_RESULT_FLAGS_EN
                chk("beat_flags", flags, b.fl);
`endif
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_hi    = out_is_hi;
        prev_cap   = in_valid && in_ready;
        prev_clr   = clear_cnt;
    end

    // Waits for IDLE, presents one result for exactly one cycle; returns 1ns after the capture edge.
    task automatic send(input logic [3:0] op, input logic [2*W-1:0] z, input logic c);
        int n = 0;
        @(posedge clock); #1;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("send_idle_timeout", in_ready, 1);
        in_valid = 1; op_select = op; z_in = z; carry_in = c;
        @(posedge clock); #1;
        in_valid = 0;
    endtask

    logic [2*W-1:0] zd;
    logic [W-1:0]   hi0, lo0;

    initial begin
        #1 clear = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_is_hi", out_is_hi, 0);
        chk("rst_hi_q", hi_q, 0);
        chk("rst_lo_q", lo_q, 0);
`ifdef ALU_RESULT_FLAGS_EN
        chk("rst_flags", flags, 0);
`endif
        #10 clear = 0;

        // add: single beat, HI/LO untouched
        out_ready = 1;
        hi0 = hi_q; lo0 = lo_q;
        send(OP_ADD, 64'h0000_0000_0000_0007, 0);
        chk("add_valid", out_valid, 1);
        chk("add_data", out_data, 7);
        chk("add_is_hi", out_is_hi, 0);
        @(posedge clock); #1;
        chk("add_ready_back", in_ready, 1);
        chk("add_valid_low", out_valid, 0);
        chk("add_hi_same", hi_q, hi0);
        chk("add_lo_same", lo_q, lo0);

        // multiply: lo beat then hi beat
        send(OP_MUL, 64'h0000_0001_FFFF_FFFE, 0);
        chk("mul_lo_data", out_data, 32'hFFFF_FFFE);
        chk("mul_lo_is_hi", out_is_hi, 0);
        chk("mul_hi_q", hi_q, 1);
        chk("mul_lo_q", lo_q, 32'hFFFF_FFFE);
        @(posedge clock); #1;
        chk("mul_hi_data", out_data, 1);
        chk("mul_hi_is_hi", out_is_hi, 1);
        chk("mul_hi_valid", out_valid, 1);
        @(posedge clock); #1;
        chk("mul_idle", in_ready, 1);

        // divide under backpressure with ignored in_valid pulses
        out_ready = 0;
        zd = {$urandom(), $urandom()};
        send(OP_DIV, zd, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; op_select = OP_MUL; z_in = ~zd;
            @(posedge clock); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, zd[W-1:0]);
            chk("bp_is_hi", out_is_hi, 0);
        end
        in_valid = 0;
        chk("bp_hi_q", hi_q, zd[2*W-1:W]);
        chk("bp_lo_q", lo_q, zd[W-1:0]);
        out_ready = 1;
        repeat (3) @(posedge clock);
        #1;

        // clear during HI_BEAT
        out_ready = 0;
        send(OP_MUL, {$urandom(), $urandom()}, 1);
        out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0;
        chk("pre_clear_is_hi", out_is_hi, 1);
        #1 clear = 1;
        clear_cnt++;
        exp_q.delete();
        exp_hi = 0; exp_lo = 0;
        #1;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_hi_q", hi_q, 0);
        chk("clr_lo_q", lo_q, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_data", out_data, 0);
        chk("clr_out_is_hi", out_is_hi, 0);
        #1 clear = 0;
        out_ready = 1;
        send(OP_ADD, 64'h0000_0000_0000_1234, 0);
        chk("after_clr_valid", out_valid, 1);
        chk("after_clr_data", out_data, 32'h1234);
        @(posedge clock); #1;

`ifdef ALU_RESULT_FLAGS_EN
        send(OP_SUB, {32'hDEAD_BEEF, 32'h0}, 1);
        chk("flags_carry_zero", flags, 3'b101);
        @(posedge clock); #1;
        send(OP_SUB, {32'h0, 32'h8000_0000}, 0);
        chk("flags_negative", flags, 3'b010);
        @(posedge clock); #1;
`endif

        // random traffic with random backpressure
        repeat (800) begin
            @(posedge clock); #1;
            in_valid  = 1'($urandom_range(0, 1));
            op_select = ops[$urandom_range(0, 7)];
            z_in      = {$urandom(), $urandom()};
            carry_in  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
        end
        in_valid = 0;
        out_ready = 1;
        for (int n = 0; n < 20 && (out_valid || exp_q.size() != 0); n++) begin
            @(posedge clock); #1;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
